// File: rtl/retire_stage_if.sv
// Retire-stage bus: ROB head window in, retire count / free-list / commit state out.
interface retire_stage_if #(
    parameter int unsigned N         = 3,
    parameter int unsigned PHYS_BITS = 6,
    parameter int unsigned ARCH_REGS = 32
);
    localparam int unsigned CntW  = $clog2(N + 1);
    localparam int unsigned ArchW = $clog2(ARCH_REGS);

    logic [N-1:0]                        rob_complete;
    logic [N-1:0]                        rob_has_dest;
    logic [N-1:0][ArchW-1:0]             rob_arch_reg;
    logic [N-1:0][PHYS_BITS-1:0]         rob_t_new;
    logic [N-1:0][PHYS_BITS-1:0]         rob_t_old;
    logic [N-1:0]                        rob_mispredict;
    logic [N-1:0]                        rob_halt;
    logic [CntW-1:0]                     rob_outputs_valid;

    logic [CntW-1:0]                     num_retiring;
    logic [N-1:0]                        free_valid;
    logic [N-1:0][PHYS_BITS-1:0]         free_reg;
    logic [ARCH_REGS-1:0][PHYS_BITS-1:0] arch_map;
    logic                                flush_valid;
    logic                                halted;
    logic [63:0]                         retired_count;
    logic                                deadlock;

    modport master (
        output rob_complete, rob_has_dest, rob_arch_reg, rob_t_new, rob_t_old,
               rob_mispredict, rob_halt, rob_outputs_valid,
        input  num_retiring, free_valid, free_reg, arch_map, flush_valid, halted,
               retired_count, deadlock
    );

    modport slave (
        input  rob_complete, rob_has_dest, rob_arch_reg, rob_t_new, rob_t_old,
               rob_mispredict, rob_halt, rob_outputs_valid,
        output num_retiring, free_valid, free_reg, arch_map, flush_valid, halted,
               retired_count, deadlock
    );
endinterface

// File: rtl/retire_stage.sv
// In-order commit stage: retires the completed prefix of the ROB head window, keeps the
// committed arch map, and sequences mispredict flushes, halt and a stall watchdog.
module retire_stage #(
    parameter int unsigned N          = 3,
    parameter int unsigned PHYS_BITS  = 6,
    parameter int unsigned ARCH_REGS  = 32,
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input logic             clock,
    input logic             reset_n,
    retire_stage_if.slave   rob
);
    localparam int unsigned CntW  = $clog2(N + 1);
    localparam int unsigned WdogW = $clog2(WDOG_LIMIT + 1);

    typedef enum logic [1:0] {StRun, StFlush, StHalted} state_e;

    state_e                              state_q, state_d;
    logic [ARCH_REGS-1:0][PHYS_BITS-1:0] arch_map_q, arch_map_d;
    logic [63:0]                         retired_count_q, retired_count_d;
    logic [WdogW-1:0]                    wdog_q, wdog_d;
    logic                                deadlock_q, deadlock_d;

    logic [N-1:0]    retiring;
    logic [N-1:0]    map_wr;
    logic [CntW-1:0] retire_cnt;
    logic            mispredict_end;
    logic            halt_end;
    logic            group_stop;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StRun;
            retired_count_q <= '0;
            wdog_q          <= '0;
            deadlock_q      <= 1'b0;
            for (int i = 0; i < int'(ARCH_REGS); i++) begin
                arch_map_q[i] <= PHYS_BITS'(i);
            end
        end else begin
            state_q         <= state_d;
            retired_count_q <= retired_count_d;
            wdog_q          <= wdog_d;
            deadlock_q      <= deadlock_d;
            arch_map_q      <= arch_map_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (mispredict_end)  state_d = StFlush;
                else if (halt_end)   state_d = StHalted;
            end
            StFlush:  state_d = StRun;
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    // Outputs: retire select and everything derived from it
    always_comb begin
        retiring       = '0;
        map_wr         = '0;
        retire_cnt     = '0;
        mispredict_end = 1'b0;
        halt_end       = 1'b0;
        group_stop     = 1'b0;
        rob.free_reg   = '0;

        if (reset_n && state_q == StRun) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!group_stop && i < int'(rob.rob_outputs_valid) && rob.rob_complete[i]) begin
                    retiring[i] = 1'b1;
                    retire_cnt  = retire_cnt + CntW'(1);
                    // The oldest mispredict/halt retires itself and closes the group
                    if (rob.rob_mispredict[i]) begin
                        mispredict_end = 1'b1;
                        group_stop     = 1'b1;
                    end else if (rob.rob_halt[i]) begin
                        halt_end   = 1'b1;
                        group_stop = 1'b1;
                    end
                end else begin
                    group_stop = 1'b1;
                end
            end
        end

        for (int i = 0; i < int'(N); i++) begin
            map_wr[i] = retiring[i] & rob.rob_has_dest[i] & (rob.rob_arch_reg[i] != '0);
            if (reset_n) rob.free_reg[i] = rob.rob_t_old[i];
        end

        rob.num_retiring  = retire_cnt;
        rob.free_valid    = map_wr;
        rob.flush_valid   = (state_q == StFlush);
        rob.halted        = (state_q == StHalted);
        rob.arch_map      = arch_map_q;
        rob.retired_count = retired_count_q;
        rob.deadlock      = deadlock_q;
    end

    // Commit datapath: map writes in slot order so the youngest writer wins
    always_comb begin
        arch_map_d = arch_map_q;
        for (int i = 0; i < int'(N); i++) begin
            if (map_wr[i]) arch_map_d[rob.rob_arch_reg[i]] = rob.rob_t_new[i];
        end
        retired_count_d = retired_count_q + 64'(retire_cnt);

        wdog_d = wdog_q;
        if (state_q == StFlush) begin
            wdog_d = '0;
        end else if (state_q == StRun) begin
            if (retire_cnt != '0) begin
                wdog_d = '0;
            end else if (rob.rob_outputs_valid != '0 && wdog_q != WdogW'(WDOG_LIMIT)) begin
                wdog_d = wdog_q + WdogW'(1);
            end
        end
        deadlock_d = deadlock_q | (wdog_q == WdogW'(WDOG_LIMIT));
    end
endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage: driver pushes per-cycle expectations, monitor compares.
module tb_retire_stage;
    logic clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    retire_stage_if #(.N(3), .PHYS_BITS(6), .ARCH_REGS(32)) bif ();

    retire_stage #(.N(3), .PHYS_BITS(6), .ARCH_REGS(32), .WDOG_LIMIT(1024)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .rob     (bif.slave)
    );

    typedef struct {
        string       name;
        int          nr;
        int          fv;
        bit          fl;
        bit          ha;
        bit          dl;
        longint      rc;
        int          map_idx;  // -1: skip
        int          map_val;
        int          fr0;      // -1: skip
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input string field, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, field, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge clock) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "num_retiring", longint'(bif.num_retiring), e.nr);
            chk(e.name, "free_valid", longint'(bif.free_valid), e.fv);
            chk(e.name, "flush_valid", longint'(bif.flush_valid), e.fl);
            chk(e.name, "halted", longint'(bif.halted), e.ha);
            chk(e.name, "deadlock", longint'(bif.deadlock), e.dl);
            chk(e.name, "retired_count", longint'(bif.retired_count), e.rc);
            if (e.map_idx >= 0)
                chk(e.name, "arch_map", longint'(bif.arch_map[e.map_idx]), e.map_val);
            if (e.fr0 >= 0)
                chk(e.name, "free_reg0", longint'(bif.free_reg[0]), e.fr0);
        end
    end

    task automatic push(input string nm, input int nr, input int fv, input bit fl, input bit ha,
                        input bit dl, input longint rc, input int mi, input int mv, input int fr0);
        exp_t e;
        e.name = nm; e.nr = nr; e.fv = fv; e.fl = fl; e.ha = ha; e.dl = dl; e.rc = rc;
        e.map_idx = mi; e.map_val = mv; e.fr0 = fr0;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        bif.rob_complete      = '0;
        bif.rob_has_dest      = '0;
        bif.rob_arch_reg      = '0;
        bif.rob_t_new         = '0;
        bif.rob_t_old         = '0;
        bif.rob_mispredict    = '0;
        bif.rob_halt          = '0;
        bif.rob_outputs_valid = '0;
    endtask

    task automatic slot(input int i, input bit c, input bit hd, input int ar, input int tn,
                        input int to, input bit mp, input bit ht);
        bif.rob_complete[i]   = c;
        bif.rob_has_dest[i]   = hd;
        bif.rob_arch_reg[i]   = 5'(ar);
        bif.rob_t_new[i]      = 6'(tn);
        bif.rob_t_old[i]      = 6'(to);
        bif.rob_mispredict[i] = mp;
        bif.rob_halt[i]       = ht;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        step();
        push("reset", 0, 0, 0, 0, 0, 0, 7, 7, 0);
        step(); reset_n = 1'b1;
        push("idle", 0, 0, 0, 0, 0, 0, 31, 31, -1);

        // All three complete
        step(); bif.rob_outputs_valid = 2'd3;
        slot(0, 1, 1, 1, 40, 1, 0, 0); slot(1, 1, 1, 2, 41, 2, 0, 0); slot(2, 1, 1, 3, 42, 3, 0, 0);
        push("full_group", 3, 3'b111, 0, 0, 0, 0, -1, 0, 1);
        step(); clr(); push("map1", 0, 0, 0, 0, 0, 3, 1, 40, -1);
        step(); push("map2", 0, 0, 0, 0, 0, 3, 2, 41, -1);
        step(); push("map3", 0, 0, 0, 0, 0, 3, 3, 42, -1);

        // Hole in the completion prefix
        step(); bif.rob_outputs_valid = 2'd3;
        slot(0, 1, 1, 4, 20, 7, 0, 0); slot(1, 0, 1, 5, 21, 8, 0, 0); slot(2, 1, 1, 6, 22, 9, 0, 0);
        push("prefix", 1, 3'b001, 0, 0, 0, 3, -1, 0, 7);
        step(); clr(); push("prefix_map4", 0, 0, 0, 0, 0, 4, 4, 20, -1);
        step(); push("prefix_map6", 0, 0, 0, 0, 0, 4, 6, 6, -1);

        // Mispredict in slot 1
        step(); bif.rob_outputs_valid = 2'd3;
        slot(0, 1, 1, 7, 30, 10, 0, 0); slot(1, 1, 1, 8, 31, 11, 1, 0); slot(2, 1, 1, 9, 32, 12, 0, 0);
        push("mispred", 2, 3'b011, 0, 0, 0, 4, -1, 0, 10);
        step(); push("flush", 0, 0, 1, 0, 0, 6, 8, 31, -1);
        step(); clr(); push("after_flush", 0, 0, 0, 0, 0, 6, 9, 9, -1);

        // Same-register collision and x0 destination
        step(); bif.rob_outputs_valid = 2'd3;
        slot(0, 1, 1, 5, 10, 14, 0, 0); slot(1, 1, 1, 0, 50, 15, 0, 0); slot(2, 1, 1, 5, 12, 16, 0, 0);
        push("collide", 3, 3'b101, 0, 0, 0, 6, -1, 0, 14);
        step(); clr(); push("collide_map5", 0, 0, 0, 0, 0, 9, 5, 12, -1);
        step(); push("x0_map", 0, 0, 0, 0, 0, 9, 0, 0, -1);

        // Halt in slot 0
        step(); bif.rob_outputs_valid = 2'd3;
        slot(0, 1, 1, 12, 60, 3, 0, 1); slot(1, 1, 1, 10, 61, 4, 0, 0); slot(2, 1, 1, 11, 62, 5, 0, 0);
        push("halt", 1, 3'b001, 0, 0, 0, 9, -1, 0, 3);
        step(); bif.rob_halt = '0;
        push("halted1", 0, 0, 0, 1, 0, 10, 12, 60, -1);
        step(); push("halted2", 0, 0, 0, 1, 0, 10, 10, 10, -1);
        step(); reset_n = 1'b0;
        push("reset_halted", 0, 0, 0, 0, 0, 0, 12, 12, 0);
        step(); reset_n = 1'b1; clr();
        push("post_reset", 0, 0, 0, 0, 0, 0, -1, 0, -1);

        // Watchdog: one valid, never complete
        for (int c = 0; c <= 1025; c++) begin
            step();
            if (c == 0) begin
                bif.rob_outputs_valid = 2'd1;
                slot(0, 0, 1, 1, 33, 13, 0, 0);
                push("wdog_start", 0, 0, 0, 0, 0, 0, -1, 0, -1);
            end else if (c == 1024) begin
                push("wdog_limit", 0, 0, 0, 0, 0, 0, -1, 0, -1);
            end else if (c == 1025) begin
                push("wdog_trip", 0, 0, 0, 0, 1, 0, -1, 0, -1);
            end
        end
        step(); clr(); push("deadlock_sticky", 0, 0, 0, 0, 1, 0, -1, 0, -1);

        // Reset in the middle of a flush
        step(); bif.rob_outputs_valid = 2'd3;
        slot(0, 1, 1, 1, 33, 13, 1, 0); slot(1, 1, 1, 2, 34, 2, 0, 0);
        push("mispred0", 1, 3'b001, 0, 0, 1, 0, -1, 0, 13);
        step(); push("flush2", 0, 0, 1, 0, 1, 1, 1, 33, -1);
        step(); reset_n = 1'b0;
        push("reset_mid_flush", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(); reset_n = 1'b1; clr();
        push("after_reset", 0, 0, 0, 0, 0, 0, 2, 2, -1);

        step(); step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
